// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants for the UART command controller
package uart_cmd_pkg;

    // Single-character command bytes, upper and lower case
    localparam logic [7:0] CMD_RUN_U  = 8'h52;
    localparam logic [7:0] CMD_RUN_L  = 8'h72;
    localparam logic [7:0] CMD_STOP_U = 8'h53;
    localparam logic [7:0] CMD_STOP_L = 8'h73;
    localparam logic [7:0] CMD_CLR_U  = 8'h43;
    localparam logic [7:0] CMD_CLR_L  = 8'h63;
    localparam logic [7:0] CMD_QRY_U  = 8'h51;
    localparam logic [7:0] CMD_QRY_L  = 8'h71;

    // Report characters
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Report FSM encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;
    localparam logic [1:0] WAIT    = 2'd3;

    // Largest value that fits in four decimal digits
    localparam int CNT_MAX = 9999;
    localparam int N_CHARS = 6;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one shift per cycle, four BCD digits
module bin2bcd_seq #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] bin,
    output logic             done,
    output logic [3:0]       bcd_thou,
    output logic [3:0]       bcd_hund,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
);

    localparam int SR_W = 16 + CNT_W;
    localparam int CW   = $clog2(CNT_W + 1);

    // Upper 16 bits hold the BCD digits, lower CNT_W bits the binary being shifted in
    logic [SR_W-1:0] sr;
    logic [CW-1:0]   cnt;

    // One double-dabble step: add 3 to any digit >= 5, then shift left
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] x);
        logic [SR_W-1:0] y;
        y = x;
        for (int i = 0; i < 4; i++) begin
            if (y[CNT_W+4*i +: 4] >= 4'd5)
                y[CNT_W+4*i +: 4] = y[CNT_W+4*i +: 4] + 4'd3;
        end
        return y << 1;
    endfunction

    // The first shift happens on the start edge so done lands CNT_W cycles after start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr   <= dabble({16'b0, bin});
                cnt  <= CW'(CNT_W - 1);
                done <= (CNT_W == 1);
            end else if (cnt != '0) begin
                sr  <= dabble(sr);
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1))
                    done <= 1'b1;
            end
        end
    end

    assign bcd_thou = sr[CNT_W+12 +: 4];
    assign bcd_hund = sr[CNT_W+8  +: 4];
    assign bcd_tens = sr[CNT_W+4  +: 4];
    assign bcd_ones = sr[CNT_W    +: 4];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - ASCII command decoder and decimal counter reporter over UART
module uart_cmd_ctrl #(
    parameter int CNT_W   = 14,
    parameter int CNT_MAX = uart_cmd_pkg::CNT_MAX,
    parameter int N_CHARS = uart_cmd_pkg::N_CHARS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             tx_done,
    input  logic [CNT_W-1:0] counter_value,
    output logic             start,
    output logic [7:0]       tx_data,
    output logic             run_en,
    output logic             clear,
    output logic             busy
);

    import uart_cmd_pkg::*;

    logic [1:0]       state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] snapshot;
    logic [CNT_W-1:0] sat_value;
    logic             conv_start;
    logic             conv_done;
    logic [3:0]       bcd_t, bcd_h, bcd_e, bcd_o;
    logic [3:0]       dig_t, dig_h, dig_e, dig_o;
    logic             is_run, is_stop, is_clr, is_qry;

    assign is_run  = (rx_data == CMD_RUN_U)  || (rx_data == CMD_RUN_L);
    assign is_stop = (rx_data == CMD_STOP_U) || (rx_data == CMD_STOP_L);
    assign is_clr  = (rx_data == CMD_CLR_U)  || (rx_data == CMD_CLR_L);
    assign is_qry  = (rx_data == CMD_QRY_U)  || (rx_data == CMD_QRY_L);

    // Values above four digits are clamped so the report never overflows
    assign sat_value = (32'(counter_value) > CNT_MAX) ? CNT_W'(CNT_MAX) : counter_value;

    // Character i of the report from the latched digits
    function automatic logic [7:0] char_at(input logic [2:0] i);
        case (i)
            3'd0:    char_at = ASCII_0 + {4'b0, dig_t};
            3'd1:    char_at = ASCII_0 + {4'b0, dig_h};
            3'd2:    char_at = ASCII_0 + {4'b0, dig_e};
            3'd3:    char_at = ASCII_0 + {4'b0, dig_o};
            3'd4:    char_at = ASCII_CR;
            default: char_at = ASCII_LF;
        endcase
    endfunction

    bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd (
        .clk      (clk),
        .reset    (reset),
        .start    (conv_start),
        .bin      (snapshot),
        .done     (conv_done),
        .bcd_thou (bcd_t),
        .bcd_hund (bcd_h),
        .bcd_tens (bcd_e),
        .bcd_ones (bcd_o)
    );

    // Run/stop/clear act in every FSM state, independent of any report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_en <= 1'b0;
            clear  <= 1'b0;
        end else begin
            clear <= rx_done && is_clr;
            if (rx_done && is_run)
                run_en <= 1'b1;
            else if (rx_done && is_stop)
                run_en <= 1'b0;
        end
    end

    // Report sequencer: snapshot, convert, then send six characters with a handshake each
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            snapshot   <= '0;
            conv_start <= 1'b0;
            busy       <= 1'b0;
            start      <= 1'b0;
            tx_data    <= 8'h00;
            dig_t      <= 4'd0;
            dig_h      <= 4'd0;
            dig_e      <= 4'd0;
            dig_o      <= 4'd0;
        end else begin
            conv_start <= 1'b0;
            start      <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_done && is_qry) begin
                        snapshot   <= sat_value;
                        busy       <= 1'b1;
                        conv_start <= 1'b1;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
                        dig_t   <= bcd_t;
                        dig_h   <= bcd_h;
                        dig_e   <= bcd_e;
                        dig_o   <= bcd_o;
                        idx     <= 3'd0;
                        start   <= 1'b1;
                        tx_data <= ASCII_0 + {4'b0, bcd_t};
                        state   <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (idx == 3'(N_CHARS - 1)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx     <= idx + 3'd1;
                            start   <= 1'b1;
                            tx_data <= char_at(idx + 3'd1);
                            state   <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - randomized self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    localparam int CNT_W = 14;
    localparam int NONE  = 1000000;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             tx_done;
    logic [CNT_W-1:0] counter_value;
    logic             start;
    logic [7:0]       tx_data;
    logic             run_en;
    logic             clear;
    logic             busy;

    int errors = 0;
    int checks = 0;
    bit model_run = 1'b0;

    int         inj_cyc[$];
    logic [7:0] inj_byte[$];

    uart_cmd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .tx_done       (tx_done),
        .counter_value (counter_value),
        .start         (start),
        .tx_data       (tx_data),
        .run_en        (run_en),
        .clear         (clear),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Expected report text: clamp, split into decimal digits, append CR LF
    function automatic logic [47:0] exp_chars(input int cv);
        int v;
        v = (cv > 9999) ? 9999 : cv;
        exp_chars = {8'(48 + v / 1000), 8'(48 + (v / 100) % 10),
                     8'(48 + (v / 10) % 10), 8'(48 + v % 10), 8'h0D, 8'h0A};
    endfunction

    function automatic bit is_cmd(input logic [7:0] b);
        return b inside {8'h52, 8'h72, 8'h53, 8'h73, 8'h43, 8'h63, 8'h51, 8'h71};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        if (b == 8'h52 || b == 8'h72) model_run = 1'b1;
        if (b == 8'h53 || b == 8'h73) model_run = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        rx_data = 8'h00;
        counter_value = '0;
        step();
        step();
        checks++;
        if ({start, tx_data, run_en, clear, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: got start=%b tx_data=%h run_en=%b clear=%b busy=%b, want all 0",
                     start, tx_data, run_en, clear, busy);
        end
        reset = 1'b0;
        model_run = 1'b0;
        step();
    endtask

    task automatic test_run_stop();
        logic [7:0] b;
        send_rx(8'h52);
        checks++;
        if (run_en !== 1'b1 || clear !== 1'b0) begin
            errors++;
            $display("FAIL run_cmd: got run_en=%b clear=%b, want 1 0", run_en, clear);
        end
        step();
        send_rx(8'h73);
        checks++;
        if (run_en !== 1'b0 || clear !== 1'b0) begin
            errors++;
            $display("FAIL stop_cmd: got run_en=%b clear=%b, want 0 0", run_en, clear);
        end
        send_rx(8'h72);
        for (int i = 0; i < 8; i++) begin
            do b = 8'($urandom_range(0, 255)); while (is_cmd(b));
            send_rx(b);
            checks++;
            if (run_en !== 1'b1 || clear !== 1'b0 || busy !== 1'b0 || start !== 1'b0) begin
                errors++;
                $display("FAIL ignored_byte %h: got run_en=%b clear=%b busy=%b start=%b, want 1 0 0 0",
                         b, run_en, clear, busy, start);
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0] cb[2];
        cb[0] = 8'h43;
        cb[1] = 8'h63;
        for (int i = 0; i < 2; i++) begin
            send_rx(cb[i]);
            checks++;
            if (clear !== 1'b1 || run_en !== 1'b1) begin
                errors++;
                $display("FAIL clear_pulse %h: got clear=%b run_en=%b, want 1 1", cb[i], clear, run_en);
            end
            step();
            checks++;
            if (clear !== 1'b0 || run_en !== 1'b1) begin
                errors++;
                $display("FAIL clear_end %h: got clear=%b run_en=%b, want 0 1", cb[i], clear, run_en);
            end
        end
    endtask

    // Issue a query and act as the transmitter; injections come from inj_cyc/inj_byte
    task automatic run_report(input logic [7:0] qb, input int cv, input int delay,
                              input int abort_after, input int cv_chg_cyc, input int cv_new);
        logic [47:0] exp;
        logic [7:0]  exp_b;
        logic [7:0]  last_tx;
        int c, ntx, pending, done_c, abort_c;
        bit model_clr, aborted;
        exp = exp_chars(cv);
        counter_value = CNT_W'(cv);
        send_rx(qb);
        c = 1; ntx = 0; pending = NONE; done_c = NONE; abort_c = NONE;
        model_clr = 1'b0; aborted = 1'b0; last_tx = 8'h00;
        while (c < 2000 && c < done_c + 20) begin
            if (c == abort_c) begin
                tx_done = 1'b0;
                rx_done = 1'b0;
                reset = 1'b1;
                #1;
                checks++;
                if ({start, tx_data, run_en, clear, busy} !== 12'h000) begin
                    errors++;
                    $display("FAIL abort_reset: got start=%b tx_data=%h run_en=%b clear=%b busy=%b, want all 0",
                             start, tx_data, run_en, clear, busy);
                end
                step();
                reset = 1'b0;
                model_run = 1'b0;
                aborted = 1'b1;
                break;
            end
            tx_done = (c == pending);
            if (c == cv_chg_cyc) counter_value = CNT_W'(cv_new);
            rx_done = 1'b0;
            for (int i = 0; i < inj_cyc.size(); i++) begin
                if (inj_cyc[i] == c) begin
                    rx_data = inj_byte[i];
                    rx_done = 1'b1;
                end
            end
            checks++;
            if (run_en !== model_run || clear !== model_clr || busy !== (c < done_c)) begin
                errors++;
                $display("FAIL ctrl_levels cycle %0d: got run_en=%b clear=%b busy=%b, want %b %b %b",
                         c, run_en, clear, busy, model_run, model_clr, c < done_c);
            end
            if (start) begin
                checks++;
                if (ntx >= 6) begin
                    errors++;
                    $display("FAIL extra_start cycle %0d: got start after %0d bytes, want 6 bytes only", c, ntx);
                end else begin
                    exp_b = exp[47-8*ntx -: 8];
                    if (tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL tx_byte %0d: got %h, want %h", ntx, tx_data, exp_b);
                    end
                end
                if (ntx == 0) begin
                    checks++;
                    if (c != CNT_W + 2) begin
                        errors++;
                        $display("FAIL first_latency: got %0d cycles, want %0d", c, CNT_W + 2);
                    end
                end
                last_tx = tx_data;
                pending = c + delay;
                ntx++;
                if (abort_after > 0 && ntx == abort_after) abort_c = c + 1;
            end else if (ntx > 0 && c < done_c) begin
                checks++;
                if (tx_data !== last_tx) begin
                    errors++;
                    $display("FAIL tx_hold cycle %0d: got %h, want %h", c, tx_data, last_tx);
                end
            end
            model_clr = rx_done && (rx_data == 8'h43 || rx_data == 8'h63);
            if (rx_done && (rx_data == 8'h52 || rx_data == 8'h72)) model_run = 1'b1;
            if (rx_done && (rx_data == 8'h53 || rx_data == 8'h73)) model_run = 1'b0;
            if (tx_done && ntx == 6) done_c = c + 1;
            step();
            c++;
        end
        tx_done = 1'b0;
        rx_done = 1'b0;
        if (!aborted) begin
            checks++;
            if (done_c == NONE || ntx != 6) begin
                errors++;
                $display("FAIL report_complete: got %0d bytes (done=%0d), want 6 bytes and busy drop",
                         ntx, done_c != NONE);
            end
        end
        inj_cyc.delete();
        inj_byte.delete();
        step();
    endtask

    task automatic test_report_1234();
        run_report(8'h51, 1234, 50, 0, NONE, 0);
    endtask

    task automatic test_saturate();
        run_report(8'h71, 12000, 7, 0, 20, 5);
    endtask

    task automatic test_mid_report();
        send_rx(8'h52);
        inj_cyc.push_back(5);  inj_byte.push_back(8'h51);
        inj_cyc.push_back(40); inj_byte.push_back(8'h71);
        inj_cyc.push_back(60); inj_byte.push_back(8'h53);
        inj_cyc.push_back(70); inj_byte.push_back(8'h78);
        run_report(8'h51, 4321, 15, 0, NONE, 0);
    endtask

    task automatic test_reset_mid();
        run_report(8'h51, 8765, 10, 2, NONE, 0);
        run_report(8'h51, 7, 3, 0, NONE, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            inj_cyc.push_back($urandom_range(1, 80));
            inj_byte.push_back(8'($urandom_range(0, 255)));
            run_report(($urandom_range(0, 1) == 1) ? 8'h51 : 8'h71,
                       $urandom_range(0, 16383), $urandom_range(1, 20), 0, NONE, 0);
        end
    endtask

    task automatic test_back_to_back();
        run_report(8'h51, 0, 1, 0, NONE, 0);
        run_report(8'h71, 9999, 1, 0, NONE, 0);
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_clear();
        test_report_1234();
        test_saturate();
        test_mid_report();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
